// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default frame/baud parameters.
package uart_pkg;

  localparam int DEF_DATAWIDTH  = 8;
  localparam int DEF_CLK_DIV    = 27;
  localparam int DEF_OVERSAMPLE = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud prescaler: counts 0..CLK_DIV-1 and flags a tick on the last count.
// A synchronous clear realigns the tick phase to a detected start edge.
module uart_baud_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST || clear)       count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + 1'b1;
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_rx_sequencer.sv
// Oversampling UART receive controller feeding the RX FIFO write port.
// Define UART_RX_PARITY_EN to expect one even-parity bit before the stop bit.
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int DATAWIDTH  = DEF_DATAWIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX,
  input  logic                 ISFULL,
  output logic                 WRITE,
  output logic [DATAWIDTH-1:0] DATA,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATAWIDTH - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] AFTER_DATA = ST_STOP;
`endif

  logic                 rx_meta, rx_s, rx_d;
  logic [2:0]           state;
  logic                 tick;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATAWIDTH-1:0] shreg;
  logic                 fall, half_due, bit_due;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  // NOTE: reset to the idle level so no false edge appears after reset,
  // unless the line really is low when reset releases.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign fall     = rx_d & ~rx_s;
  assign half_due = tick && (tick_cnt == HALF_LAST);
  assign bit_due  = tick && (tick_cnt == FULL_LAST);

  // Prescaler is held cleared while idle so its phase starts at the edge.
  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .clear(state == ST_IDLE),
    .tick (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      DATA      <= '0;
      WRITE     <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
      BUSY      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PARITY_ERR <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      WRITE     <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PARITY_ERR <= 1'b0;
`endif
      // NOTE: state-specific assignments below come later and therefore win.
      if (tick) tick_cnt <= (tick_cnt == FULL_LAST) ? '0 : tick_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          tick_cnt <= '0;
          bit_idx  <= '0;
`ifdef UART_RX_PARITY_EN
          par_bad  <= 1'b0;
`endif
          if (fall) begin
            state <= ST_START;
            BUSY  <= 1'b1;
          end
        end
        ST_START: if (half_due) begin
          tick_cnt <= '0;
          if (rx_s) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end else begin
            state <= ST_DATA;
          end
        end
        ST_DATA: if (bit_due) begin
          shreg   <= {rx_s, shreg[DATAWIDTH-1:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) state <= AFTER_DATA;
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: if (bit_due) begin
          par_bad <= (^shreg) ^ rx_s;
          state   <= ST_STOP;
        end
`endif
        ST_STOP: if (bit_due) begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
          if (!rx_s) begin
            FRAME_ERR <= 1'b1;
            state     <= ST_WAIT_IDLE;
            BUSY      <= 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bad) PARITY_ERR <= 1'b1;
`endif
          else if (ISFULL) OVERRUN <= 1'b1;
          else begin
            DATA  <= shreg;
            WRITE <= 1'b1;
          end
        end
        ST_WAIT_IDLE: if (rx_s) begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Self-checking bench for uart_rx_sequencer: directed scenarios plus random frames
// scored against a frame-level outcome/timing model.
`timescale 1ns/1ps
module tb_uart_rx_sequencer;

  localparam int DW      = 8;
  localparam int CLK_DIV = 4;
  localparam int OS      = 16;
  localparam int BIT_T   = CLK_DIV * OS;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int FRAME_BITS = 1 + DW + NPAR + 1;
  // Pin edge -> result pulse: 2 sync stages, half bit, remaining whole bits, output register.
  localparam int RESULT_LAT = 2 + BIT_T / 2 + (DW + NPAR + 1) * BIT_T + 1;

  typedef enum {EV_WRITE, EV_FRAME, EV_PARITY, EV_OVERRUN} ev_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX = 1'b1;
  logic          ISFULL = 1'b0;
  logic          WRITE, FRAME_ERR, PARITY_ERR, OVERRUN, BUSY;
  logic [DW-1:0] DATA;

  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  int            n_wr = 0, n_fe = 0, n_pe = 0, n_ov = 0;
  int            last_evt = -1;
  logic [DW-1:0] exp_data = '0;

  uart_rx_sequencer #(.DATAWIDTH(DW), .CLK_DIV(CLK_DIV), .OVERSAMPLE(OS)) dut (
    .CLK(CLK), .RST(RST), .RX(RX), .ISFULL(ISFULL), .WRITE(WRITE), .DATA(DATA),
    .FRAME_ERR(FRAME_ERR), .PARITY_ERR(PARITY_ERR), .OVERRUN(OVERRUN), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor: each high cycle counts once, so a stretched pulse shows as an extra event.
  always @(negedge CLK) begin
    if (!RST) begin
      if (WRITE)      begin n_wr++; last_evt = cyc; end
      if (FRAME_ERR)  begin n_fe++; last_evt = cyc; end
      if (PARITY_ERR) begin n_pe++; last_evt = cyc; end
      if (OVERRUN)    begin n_ov++; last_evt = cyc; end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) @(negedge CLK);
  endtask

  function automatic ev_t predict(input bit par_ok, input bit stop, input bit full);
    if (!stop)   return EV_FRAME;
    if (!par_ok) return EV_PARITY;
    if (full)    return EV_OVERRUN;
    return EV_WRITE;
  endfunction

  // Drives one frame from the current cycle; abort_at >= 0 resets mid-way through that bit.
  task automatic send_frame(input logic [DW-1:0] d, input bit par_ok, input bit stop,
                            input bit full, input int abort_at);
    logic [FRAME_BITS-1:0] bits;
    int t0;
    bits = '0;
    for (int i = 0; i < DW; i++) bits[1+i] = d[i];
`ifdef UART_RX_PARITY_EN
    bits[1+DW] = (^d) ^ !par_ok;
`endif
    bits[FRAME_BITS-1] = stop;
    ISFULL = full;
    t0 = cyc;
    for (int i = 0; i < FRAME_BITS; i++) begin
      wait_to(t0 + i * BIT_T);
      RX = bits[i];
      if (i == abort_at) begin
        wait_to(cyc + BIT_T / 2);
        RST = 1'b1;
        wait_to(cyc + 3);
        RX = 1'b1;
        ISFULL = 1'b0;
        RST = 1'b0;
        return;
      end
    end
    wait_to(t0 + FRAME_BITS * BIT_T);
    if (stop) RX = 1'b1;
    ISFULL = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [DW-1:0] d, input bit par_ok,
                           input bit stop, input bit full, input int hold);
    int w0, f0, p0, o0, t0;
    ev_t ev;
    w0 = n_wr; f0 = n_fe; p0 = n_pe; o0 = n_ov;
    ev = predict(par_ok, stop, full);
    t0 = cyc;
    send_frame(d, par_ok, stop, full, -1);
    if (!stop) begin
      wait_to(cyc + hold);
      check({tag, " busy_wait_idle"}, 32'(BUSY), 32'd1);
      RX = 1'b1;
    end
    wait_to(cyc + 2 * BIT_T);
    if (ev == EV_WRITE) exp_data = d;
    check({tag, " write_cnt"},   n_wr - w0, 32'(ev == EV_WRITE));
    check({tag, " frame_cnt"},   n_fe - f0, 32'(ev == EV_FRAME));
    check({tag, " parity_cnt"},  n_pe - p0, 32'(ev == EV_PARITY));
    check({tag, " overrun_cnt"}, n_ov - o0, 32'(ev == EV_OVERRUN));
    check({tag, " result_cyc"},  last_evt, t0 + RESULT_LAT);
    check({tag, " data"},        32'(DATA), 32'(exp_data));
    check({tag, " busy_after"},  32'(BUSY), 32'd0);
  endtask

  initial begin
    int t0, w0, f0;
    logic [DW-1:0] rd;
    bit rs, rf, rp;

    // Reset values
    wait_to(4);
    check("rst write", 32'(WRITE), 32'd0);
    check("rst data",  32'(DATA), 32'd0);
    check("rst pulses", 32'({FRAME_ERR, PARITY_ERR, OVERRUN}), 32'd0);
    check("rst busy",  32'(BUSY), 32'd0);
    RST = 1'b0;
    wait_to(cyc + 20);

    run_frame("good_a5", 8'hA5, 1, 1, 0, 0);
    run_frame("full_3c", 8'h3C, 1, 1, 1, 0);
    run_frame("break_00", 8'h00, 1, 0, 0, 2000);
    run_frame("after_break_55", 8'h55, 1, 1, 0, 0);

    // Short low glitch: start sample sees 1, FSM drops back to idle.
    w0 = n_wr + n_fe + n_pe + n_ov;
    t0 = cyc;
    RX = 1'b0;
    wait_to(t0 + 20);
    RX = 1'b1;
    wait_to(t0 + 2 + BIT_T / 2);
    check("glitch busy_at_sample", 32'(BUSY), 32'd1);
    wait_to(t0 + 2 + BIT_T / 2 + 1);
    check("glitch busy_after", 32'(BUSY), 32'd0);
    wait_to(cyc + 2 * BIT_T);
    check("glitch no_pulses", n_wr + n_fe + n_pe + n_ov, w0);

    // Reset during data bit 4 of 0xFF discards the frame and clears DATA.
    w0 = n_wr + n_fe + n_pe + n_ov;
    send_frame(8'hFF, 1, 1, 0, 5);
    exp_data = '0;
    wait_to(cyc + 1);
    check("abort busy", 32'(BUSY), 32'd0);
    check("abort data", 32'(DATA), 32'd0);
    wait_to(cyc + 2 * BIT_T);
    check("abort no_pulses", n_wr + n_fe + n_pe + n_ov, w0);
    run_frame("after_abort_12", 8'h12, 1, 1, 0, 0);

`ifdef UART_RX_PARITY_EN
    run_frame("par_bad_07", 8'h07, 0, 1, 0, 0);
    run_frame("par_good_07", 8'h07, 1, 1, 0, 0);
`endif

    // Random frames against the outcome model.
    for (int i = 0; i < 8; i++) begin
      rd = DW'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      rf = ($urandom_range(0, 3) == 0);
      rp = (NPAR == 0) || ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rand%0d", i), rd, rp, rs, rf, $urandom_range(1, 300));
      wait_to(cyc + $urandom_range(1, 40));
    end

    // Line low while reset releases: synchronizer sees an edge, frame ends in FRAME_ERR.
    RX = 1'b0;
    RST = 1'b1;
    wait_to(cyc + 3);
    f0 = n_fe;
    w0 = n_wr;
    t0 = cyc;
    RST = 1'b0;
    wait_to(t0 + RESULT_LAT + BIT_T);
    check("low_rst frame_cnt", n_fe - f0, 32'd1);
    check("low_rst result_cyc", last_evt, t0 + RESULT_LAT);
    check("low_rst no_write", n_wr - w0, 32'd0);
    check("low_rst busy", 32'(BUSY), 32'd1);
    RX = 1'b1;
    wait_to(cyc + 5);
    check("low_rst busy_release", 32'(BUSY), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
